// File: rtl/match_event_pkg.sv
// -----------------------------------------------------------------------------
// match_event_pkg
// Shared definitions for the match event logger:
//   - default widths for the timestamp, run length, FIFO depth and counters
//   - match_evt_t : one logged event {start timestamp, run length}
//   - run_state_t : state of the run-coalescing FSM
// -----------------------------------------------------------------------------
package match_event_pkg;

    localparam int DEF_TS_W  = 16;
    localparam int DEF_RUN_W = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef struct packed {
        logic [DEF_TS_W-1:0]  ts;
        logic [DEF_RUN_W-1:0] run;
    } match_evt_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } run_state_t;

endpackage

// File: rtl/match_event_logger_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head output.
//   clk, reset : clock, asynchronous active-high reset
//   flush      : synchronous flush, same effect as reset
//   push, din  : write request and data; accepted when not full, or when full
//                and a pop happens at the same edge
//   pop        : remove the head; ignored while empty
//   dout       : registered head entry, all zeros while empty
//   full/empty : occupancy flags
//   level      : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign level   = count;

    // A pop frees a slot at the same edge, so a full FIFO can still accept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    // The next head is the entry at the new read pointer; when that slot is
    // the one being written this edge (FIFO empty after the pop), bypass din.
    always_comb begin
        head_next = '0;
        if (count_next != '0) begin
            if (do_push && (wr_ptr == rd_next)) begin
                head_next = din;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            dout   <= head_next;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are meaningful, so stale contents are never
    // observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/match_event_logger.sv
// -----------------------------------------------------------------------------
// match_event_logger
// Coalesces runs of consecutive detector matches into {start ts, run length}
// events, queues them in a FIFO drained over valid/ready, and keeps saturating
// statistics.
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous flush with the same effect as reset
//   match_in     : detector output, sampled every cycle
//   evt_valid    : FIFO head holds an event
//   evt_ready    : consumer accepts the head when high with evt_valid
//   evt_ts       : start timestamp of the head event (0 while empty)
//   evt_run      : run length of the head event (0 while empty)
//   match_count  : total cycles with match_in=1, saturating
//   drop_count   : events lost to a full FIFO, saturating
//   overflow     : sticky, set on the first drop
//   fifo_level   : number of queued events
// -----------------------------------------------------------------------------
module match_event_logger
    import match_event_pkg::*;
#(
    parameter int TS_W  = DEF_TS_W,
    parameter int RUN_W = DEF_RUN_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     match_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_ts,
    output logic [RUN_W-1:0]         evt_run,
    output logic [CNT_W-1:0]         match_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int EVT_W = TS_W + RUN_W;

    run_state_t       state;
    logic [TS_W-1:0]  ts_cnt;
    logic [TS_W-1:0]  start_ts;
    logic [RUN_W-1:0] run_len;
    logic [EVT_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_req;
    logic             do_pop;
    logic             drop;

    // A run ends at the first edge that samples match_in low.
    assign push_req  = (state == S_RUN) && !match_in;
    assign evt_valid = !fifo_empty;
    assign do_pop    = evt_valid && evt_ready;
    assign drop      = push_req && fifo_full && !do_pop;

    assign evt_ts    = fifo_dout[EVT_W-1:RUN_W];
    assign evt_run   = fifo_dout[RUN_W-1:0];

    // Timestamp counter and run FSM. Clear abandons any partial run.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt   <= '0;
            state    <= S_IDLE;
            start_ts <= '0;
            run_len  <= '0;
        end else if (clear) begin
            ts_cnt   <= '0;
            state    <= S_IDLE;
            start_ts <= '0;
            run_len  <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    if (match_in) begin
                        state    <= S_RUN;
                        start_ts <= ts_cnt;
                        run_len  <= RUN_W'(1);
                    end
                end
                S_RUN: begin
                    if (match_in) begin
                        // Long runs keep going but the length sticks at max.
                        if (run_len != '1) begin
                            run_len <= run_len + 1'b1;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating statistics and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            match_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (match_in && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (push_req),
        .pop   (evt_ready),
        .din   ({start_ts, run_len}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_match_event_logger.sv
// -----------------------------------------------------------------------------
// tb_match_event_logger
// Self-checking bench: a directed vector table, hand-written corner-case
// sequences, and a randomized phase compared against an event-queue model.
// -----------------------------------------------------------------------------
module tb_match_event_logger;
    import match_event_pkg::*;

    localparam int TS_W  = 16;
    localparam int RUN_W = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   clear;
    logic                   match_in;
    logic                   evt_ready;
    logic                   evt_valid;
    logic [TS_W-1:0]        evt_ts;
    logic [RUN_W-1:0]       evt_run;
    logic [CNT_W-1:0]       match_count;
    logic [CNT_W-1:0]       drop_count;
    logic                   overflow;
    logic [$clog2(DEPTH):0] fifo_level;

    int checks = 0;
    int errors = 0;

    match_event_logger #(
        .TS_W  (TS_W),
        .RUN_W (RUN_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .match_in    (match_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ts      (evt_ts),
        .evt_run     (evt_run),
        .match_count (match_count),
        .drop_count  (drop_count),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of whole events plus run bookkeeping.
    match_evt_t mq[$];
    int         m_ts;
    bit         m_in_run;
    int         m_start;
    int         m_len;
    int         m_mc;
    int         m_drop;
    bit         m_ovf;

    task automatic model_reset();
        mq.delete();
        m_ts     = 0;
        m_in_run = 0;
        m_start  = 0;
        m_len    = 0;
        m_mc     = 0;
        m_drop   = 0;
        m_ovf    = 0;
    endtask

    task automatic model_edge(input logic m, input logic r, input logic c);
        match_evt_t e;
        if (c) begin
            model_reset();
        end else begin
            if (r && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (m_in_run && !m) begin
                if (mq.size() < DEPTH) begin
                    e.ts  = 16'(m_start);
                    e.run = 8'(m_len);
                    mq.push_back(e);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_in_run = 0;
            end else if (m) begin
                if (!m_in_run) begin
                    m_in_run = 1;
                    m_start  = m_ts;
                    m_len    = 1;
                end else if (m_len < 255) begin
                    m_len++;
                end
            end
            if (m && m_mc < 65535) m_mc++;
            m_ts = (m_ts + 1) % 65536;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs for one edge, advance the model, return at the negedge.
    task automatic tick(input logic m, input logic r, input logic c);
        match_in  = m;
        evt_ready = r;
        clear     = c;
        @(posedge clk);
        model_edge(m, r, c);
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        logic        exp_v;
        logic [31:0] exp_ts;
        logic [31:0] exp_run;
        exp_v   = (mq.size() > 0);
        exp_ts  = exp_v ? 32'(mq[0].ts) : 32'd0;
        exp_run = exp_v ? 32'(mq[0].run) : 32'd0;
        check({tag, " evt_valid"},   32'(evt_valid),   32'(exp_v));
        check({tag, " evt_ts"},      32'(evt_ts),      exp_ts);
        check({tag, " evt_run"},     32'(evt_run),     exp_run);
        check({tag, " fifo_level"},  32'(fifo_level),  32'(mq.size()));
        check({tag, " match_count"}, 32'(match_count), 32'(m_mc));
        check({tag, " drop_count"},  32'(drop_count),  32'(m_drop));
        check({tag, " overflow"},    32'(overflow),    32'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        check({tag, " evt_valid"},   32'(evt_valid),   32'd0);
        check({tag, " evt_ts"},      32'(evt_ts),      32'd0);
        check({tag, " evt_run"},     32'(evt_run),     32'd0);
        check({tag, " fifo_level"},  32'(fifo_level),  32'd0);
        check({tag, " match_count"}, 32'(match_count), 32'd0);
        check({tag, " drop_count"},  32'(drop_count),  32'd0);
        check({tag, " overflow"},    32'(overflow),    32'd0);
    endtask

    typedef struct {
        logic m;
        logic r;
        logic v;
        int   ts;
        int   run;
        int   mc;
    } vec_t;

    vec_t tbl[19];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected state after each edge; edge i samples ts_cnt=i.
        // Single match at ts=5, then a 4-cycle run at ts=10 and one at ts=16.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 0,  0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 0,  0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 0,  0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 0,  0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 0,  0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 0,  0, 1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 5,  1, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 0,  0, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 0,  0, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 0,  0, 1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 0,  0, 2};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 0,  0, 3};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 0,  0, 4};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 0,  0, 5};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 10, 4, 5};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 0,  0, 5};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 0,  0, 6};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 16, 1, 6};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 0,  0, 6};

        reset     = 1'b1;
        clear     = 1'b0;
        match_in  = 1'b0;
        evt_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 19; i++) begin
            tick(tbl[i].m, tbl[i].r, 1'b0);
            check($sformatf("tbl%0d evt_valid", i),   32'(evt_valid),   32'(tbl[i].v));
            check($sformatf("tbl%0d evt_ts", i),      32'(evt_ts),      32'(tbl[i].ts));
            check($sformatf("tbl%0d evt_run", i),     32'(evt_run),     32'(tbl[i].run));
            check($sformatf("tbl%0d match_count", i), 32'(match_count), 32'(tbl[i].mc));
            check($sformatf("tbl%0d fifo_level", i),  32'(fifo_level),  32'(tbl[i].v));
            check($sformatf("tbl%0d drop_count", i),  32'(drop_count),  32'd0);
        end

        // Run length saturation: 300 matching cycles give one event of 255.
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("sat fifo_level",  32'(fifo_level),  32'd1);
        check("sat evt_valid",   32'(evt_valid),   32'd1);
        check("sat evt_ts",      32'(evt_ts),      32'd0);
        check("sat evt_run",     32'(evt_run),     32'd255);
        check("sat match_count", 32'(match_count), 32'd300);
        tick(1'b0, 1'b1, 1'b0);
        check("sat drained", 32'(evt_valid), 32'd0);

        // Overflow: 10 isolated matches into a stalled FIFO of 8.
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        check("ovf fifo_level", 32'(fifo_level), 32'd8);
        check("ovf drop_count", 32'(drop_count), 32'd2);
        check("ovf overflow",   32'(overflow),   32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ovf drain%0d valid", k), 32'(evt_valid), 32'd1);
            check($sformatf("ovf drain%0d ts", k),    32'(evt_ts),    32'(2 * k));
            check($sformatf("ovf drain%0d run", k),   32'(evt_run),   32'd1);
            tick(1'b0, 1'b1, 1'b0);
        end
        check("ovf drained valid", 32'(evt_valid),  32'd0);
        check("ovf drained level", 32'(fifo_level), 32'd0);

        // Full FIFO: a run ends at the same edge as a pop.
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        check("fullpop pre level", 32'(fifo_level), 32'd8);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        check("fullpop level",    32'(fifo_level), 32'd8);
        check("fullpop drop",     32'(drop_count), 32'd0);
        check("fullpop overflow", 32'(overflow),   32'd0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fullpop drain%0d ts", k), 32'(evt_ts), 32'(2 * (k + 1)));
            tick(1'b0, 1'b1, 1'b0);
        end
        check("fullpop drained", 32'(evt_valid), 32'd0);

        // Clear during the 3rd cycle of a run with 2 events queued.
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        check("clr queued level", 32'(fifo_level), 32'd2);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check_zero("clr");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
        check("clr after valid", 32'(evt_valid),  32'd0);
        check("clr after level", 32'(fifo_level), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0);
            compare_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-run, away from any clock edge.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        check_zero("areset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        compare_model("post_areset0");
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        compare_model("post_areset1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
